// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches ps2c/ps2d, deframes
// 11-bit frames and reports good scan codes or dropped-frame errors.
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_out,
  output logic       scan_done_tick,
  output logic       err_tick,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

  logic [1:0]            ps2c_sync_reg;
  logic [1:0]            ps2d_sync_reg;
  logic [FILTER_LEN-1:0] filter_reg;
  logic                  f_clk_reg;
  logic                  f_clk_prev_reg;
  logic                  fall_edge;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic [9:0]            shift_reg;
  logic [9:0]            shift_next;
  logic [TW-1:0]         tmo_reg;

  // Input path: 2-flop synchronisers, then a level filter on the clock line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_sync_reg  <= 2'b11;
      ps2d_sync_reg  <= 2'b11;
      filter_reg     <= '1;
      f_clk_reg      <= 1'b1;
      f_clk_prev_reg <= 1'b1;
    end else begin
      ps2c_sync_reg  <= {ps2c_sync_reg[0], ps2c};
      ps2d_sync_reg  <= {ps2d_sync_reg[0], ps2d};
      filter_reg     <= {filter_reg[FILTER_LEN-2:0], ps2c_sync_reg[1]};
      if (&filter_reg)
        f_clk_reg <= 1'b1;
      else if (~|filter_reg)
        f_clk_reg <= 1'b0;
      f_clk_prev_reg <= f_clk_reg;
    end
  end

  assign fall_edge  = f_clk_prev_reg & ~f_clk_reg;
  assign shift_next = {ps2d_sync_reg[1], shift_reg[9:1]};

  // Frame verdict is registered on the stop-bit edge so ticks line up with LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      tmo_reg        <= '0;
      scan_out       <= '0;
      err_code       <= '0;
      scan_done_tick <= 1'b0;
      err_tick       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      scan_done_tick <= 1'b0;
      err_tick       <= 1'b0;
      case (state_reg)
        IDLE: begin
          tmo_reg <= '0;
          if (fall_edge && rx_en && !ps2d_sync_reg[1]) begin
            state_reg <= DPS;
            cnt_reg   <= 4'd10;
            busy      <= 1'b1;
          end
        end
        DPS: begin
          if (fall_edge) begin
            tmo_reg   <= '0;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              state_reg <= LOAD;
              if (!(^shift_next[8:0])) begin
                err_tick <= 1'b1;
                err_code <= 2'b01;
              end else if (!shift_next[9]) begin
                err_tick <= 1'b1;
                err_code <= 2'b10;
              end else begin
                scan_out       <= shift_next[7:0];
                scan_done_tick <= 1'b1;
              end
            end
          end else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            tmo_reg   <= '0;
            err_tick  <= 1'b1;
            err_code  <= 2'b11;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        LOAD: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, parity/stop/timeout errors, glitches,
// rx_en gating and mid-frame reset.
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] scan_out;
  logic       scan_done_tick;
  logic       err_tick;
  logic [1:0] err_code;
  logic       busy;

  int passed = 0;
  int total  = 0;

  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         viol_cnt = 0;
  logic [7:0] last_scan = 8'h00;
  bit         busy_seen = 1'b0;
  logic       prev_tick = 1'b0;
  bit         clr_busy_seen = 1'b0;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(20000)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .scan_out(scan_out), .scan_done_tick(scan_done_tick), .err_tick(err_tick),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (scan_done_tick) begin
      done_cnt  <= done_cnt + 1;
      last_scan <= scan_out;
    end
    if (err_tick)
      err_cnt <= err_cnt + 1;
    if ((scan_done_tick && err_tick) || ((scan_done_tick || err_tick) && prev_tick))
      viol_cnt <= viol_cnt + 1;
    prev_tick <= scan_done_tick | err_tick;
    if (clr_busy_seen)
      busy_seen <= 1'b0;
    else if (busy)
      busy_seen <= 1'b1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_busy_seen();
    clr_busy_seen = 1'b1;
    wait_cyc(1);
    clr_busy_seen = 1'b0;
    wait_cyc(1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Sends nbits of {stop,par,d,start} LSB first; 40-cycle half bits.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit glitch, input int en_off_bit);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == en_off_bit) rx_en = 1'b0;
      if (glitch) begin
        wait_cyc(7); ps2c = 1'b0; wait_cyc(6); ps2c = 1'b1; wait_cyc(7);
      end else begin
        wait_cyc(20);
      end
      ps2d = bits[i];
      wait_cyc(20);
      ps2c = 1'b0;
      wait_cyc(40);
      ps2c = 1'b1;
    end
    wait_cyc(40);
    ps2d = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(1);
    check("reset_scan_out", 32'(scan_out), 32'h00);
    check("reset_err_code", 32'(err_code), 32'h0);
    check("reset_done_tick", 32'(scan_done_tick), 32'h0);
    check("reset_err_tick", 32'(err_tick), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    wait_cyc(20);
  endtask

  task automatic test_single();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    clear_busy_seen();
    send_frame(8'h45, 1'b0, 1'b1, 11, 1'b0, -1);
    check("single_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("single_scan", 32'(last_scan), 32'h45);
    check("single_scan_out", 32'(scan_out), 32'h45);
    check("single_no_err", 32'(err_cnt - e0), 32'd0);
    check("single_busy_seen", 32'(busy_seen), 32'd1);
    check("single_busy_end", 32'(busy), 32'd0);
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check("b2b_scan1", 32'(last_scan), 32'h1C);
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, -1);
    check("b2b_scan2", 32'(last_scan), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check("b2b_scan3", 32'(last_scan), 32'h1C);
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);
    check("b2b_no_err", 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic test_errors();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h45, 1'b1, 1'b1, 11, 1'b0, -1);
    check("parity_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("parity_err_code", 32'(err_code), 32'h1);
    check("parity_no_done", 32'(done_cnt - d0), 32'd0);
    check("parity_scan_held", 32'(scan_out), 32'h1C);
    send_frame(8'h45, 1'b0, 1'b0, 11, 1'b0, -1);
    check("stop_err_cnt", 32'(err_cnt - e0), 32'd2);
    check("stop_err_code", 32'(err_code), 32'h2);
    check("stop_no_done", 32'(done_cnt - d0), 32'd0);
    wait_cyc(200);
  endtask

  task automatic test_timeout();
    int e0, d0;
    e0 = err_cnt;
    send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0, -1);
    check("tmo_busy_mid", 32'(busy), 32'd1);
    check("tmo_no_early_err", 32'(err_cnt - e0), 32'd0);
    wait_cyc(20100);
    check("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'h3);
    check("tmo_busy_end", 32'(busy), 32'd0);
    d0 = done_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check("tmo_next_done", 32'(done_cnt - d0), 32'd1);
    check("tmo_next_scan", 32'(scan_out), 32'h1C);
  endtask

  task automatic test_glitch_and_enable();
    int d0;
    d0 = done_cnt;
    clear_busy_seen();
    wait_cyc(10); ps2c = 1'b0; wait_cyc(6); ps2c = 1'b1; wait_cyc(40);
    check("glitch_idle_busy", 32'(busy_seen), 32'd0);
    send_frame(8'h45, 1'b0, 1'b1, 11, 1'b1, -1);
    check("glitch_frame_done", 32'(done_cnt - d0), 32'd1);
    check("glitch_frame_scan", 32'(last_scan), 32'h45);
    d0 = done_cnt;
    rx_en = 1'b0;
    clear_busy_seen();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1);
    check("rxen_off_no_done", 32'(done_cnt - d0), 32'd0);
    check("rxen_off_no_busy", 32'(busy_seen), 32'd0);
    check("rxen_off_scan_held", 32'(scan_out), 32'h45);
    rx_en = 1'b1;
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, 3);
    check("rxen_drop_mid_done", 32'(done_cnt - d0), 32'd1);
    check("rxen_drop_mid_scan", 32'(scan_out), 32'hF0);
    rx_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h33, 1'b1, 1'b1, 5, 1'b0, -1);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_scan_out", 32'(scan_out), 32'h00);
    check("rstmid_err_code", 32'(err_code), 32'h0);
    wait_cyc(50);
    check("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rstmid_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, -1);
    check("rstmid_next_done", 32'(done_cnt - d0), 32'd1);
    check("rstmid_next_scan", 32'(scan_out), 32'hF0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_glitch_and_enable();
    test_reset_mid_frame();
    check("tick_overlap_viol", 32'(viol_cnt), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
